mgmt_tx_frame_buffer: RTL and testbench

Single-clock transmit frame buffer between the management register interface and the management Ethernet TX clock-domain crossing. It accepts frame bytes written one at a time by firmware over QSPI, holds them until the frame is committed, and then streams whole frames out over a valid/ready byte stream. Frames that overflow the buffer or exceed the maximum length are discarded atomically and counted. Uncommitted or partial frames never reach the output.

---
 rtl/mgmt_tx_frame_buffer.sv | 141 ++++++++++++++
 tb/tb_mgmt_tx_frame_buffer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mgmt_tx_frame_buffer.sv
// rtl/mgmt_tx_frame_buffer.sv - transmit frame buffer: byte-wise frame writes, atomic commit/drop, valid/ready byte stream out
module mgmt_tx_frame_buffer #(
    parameter int DATA_DEPTH  = 4096,
    parameter int FRAME_SLOTS = 16,
    parameter int MAX_FRAME   = 2047
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [7:0]                     wr_data,
    input  logic                           wr_commit,
    output logic                           tx_valid,
    output logic [7:0]                     tx_data,
    output logic                           tx_last,
    input  logic                           tx_ready,
    output logic [$clog2(DATA_DEPTH):0]    free_bytes,
    output logic [$clog2(FRAME_SLOTS):0]   frames_pending,
    output logic [15:0]                    drop_count
);
    localparam int AW = $clog2(DATA_DEPTH);
    localparam int FW = $clog2(FRAME_SLOTS);
    localparam logic [AW:0]   DEPTH_V  = (AW+1)'(DATA_DEPTH);
    localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [FW:0]   SLOTS_V  = (FW+1)'(FRAME_SLOTS);
    localparam logic [FW:0]   SLOT_ONE = (FW+1)'(1);
    localparam logic [11:0]   MAX_V    = 12'(MAX_FRAME);

    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;
    state_t state, state_nx;

    logic [7:0]    mem [DATA_DEPTH];
    logic [11:0]   len_mem [FRAME_SLOTS];
    logic [AW:0]   wr_tent, wr_cmt, rd_ptr, fill;
    logic [FW:0]   lf_wp, lf_rp;
    logic [11:0]   cur_len, rem, frame_len;
    logic          cur_bad, store, byte_bad, frame_bad, accept, drop;
    logic          hs, last_hs, pop, rd_en;
    logic [AW-1:0] rd_addr;

    assign fill       = wr_tent - rd_ptr;
    assign free_bytes = DEPTH_V - fill;
    assign tx_valid   = (state == SEND);
    assign tx_last    = tx_valid && (rem == 12'd1);
    assign hs         = tx_valid && tx_ready;
    assign last_hs    = hs && (rem == 12'd1);
    assign pop        = (state == IDLE) && (lf_wp != lf_rp);

    // frames_pending bounds the length FIFO occupancy, so it doubles as the full flag
    always_comb begin
        store     = wr_en && (fill != DEPTH_V) && (cur_len != MAX_V);
        byte_bad  = wr_en && !store;
        frame_len = cur_len + {11'd0, store};
        frame_bad = cur_bad || byte_bad || (frame_len == 12'd0) || (frames_pending == SLOTS_V);
        accept    = wr_commit && !frame_bad;
        drop      = wr_commit && frame_bad;
    end

    always_ff @(posedge clk) begin
        if (store) mem[wr_tent[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (accept) len_mem[lf_wp[FW-1:0]] <= frame_len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_tent    <= '0;
            wr_cmt     <= '0;
            cur_len    <= '0;
            cur_bad    <= 1'b0;
            drop_count <= '0;
            lf_wp      <= '0;
        end else begin
            if (drop)
                wr_tent <= wr_cmt;
            else if (store)
                wr_tent <= wr_tent + PTR_ONE;
            if (accept) begin
                wr_cmt <= store ? wr_tent + PTR_ONE : wr_tent;
                lf_wp  <= lf_wp + SLOT_ONE;
            end
            if (wr_commit) begin
                cur_len <= '0;
                cur_bad <= 1'b0;
            end else begin
                if (store)    cur_len <= cur_len + 12'd1;
                if (byte_bad) cur_bad <= 1'b1;
            end
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pop) state_nx = FETCH;
            FETCH:   state_nx = SEND;
            SEND:    if (last_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Prefetch the following byte during a handshake so a frame streams without bubbles
    always_comb begin
        rd_en   = (state == FETCH) || (hs && rem != 12'd1);
        rd_addr = (state == FETCH) ? rd_ptr[AW-1:0] : rd_ptr[AW-1:0] + ADDR_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rd_ptr         <= '0;
            rem            <= '0;
            lf_rp          <= '0;
            frames_pending <= '0;
        end else begin
            state <= state_nx;
            if (pop) begin
                rem   <= len_mem[lf_rp[FW-1:0]];
                lf_rp <= lf_rp + SLOT_ONE;
            end else if (hs) begin
                rem <= rem - 12'd1;
            end
            if (hs) rd_ptr <= rd_ptr + PTR_ONE;
            case ({accept, last_hs})
                2'b10:   frames_pending <= frames_pending + SLOT_ONE;
                2'b01:   frames_pending <= frames_pending - SLOT_ONE;
                default: frames_pending <= frames_pending;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            tx_data <= 8'd0;
        else if (rd_en)
            tx_data <= mem[rd_addr];
    end
endmodule

// File: tb/tb_mgmt_tx_frame_buffer.sv
// tb/tb_mgmt_tx_frame_buffer.sv - directed self-checking bench for mgmt_tx_frame_buffer
module tb_mgmt_tx_frame_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'd0;
    logic        wr_commit = 1'b0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic        tx_ready = 1'b0;
    logic [12:0] free_bytes;
    logic [4:0]  frames_pending;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int exp_drops = 0;

    logic [7:0] rx_data [$];
    logic       rx_last [$];
    int         rx_cyc [$];
    int         valid_seen = 0;
    int         first_valid_cyc = -1;
    int         stall_err = 0;
    logic       chk_en = 1'b0;
    logic       prev_stalled = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic       prev_last = 1'b0;

    mgmt_tx_frame_buffer dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_commit(wr_commit),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
        .free_bytes(free_bytes), .frames_pending(frames_pending), .drop_count(drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            if (tx_valid === 1'b1) begin
                valid_seen++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (prev_stalled && (tx_valid !== 1'b1 || tx_data !== prev_data || tx_last !== prev_last))
                stall_err++;
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                rx_data.push_back(tx_data);
                rx_last.push_back(tx_last);
                rx_cyc.push_back(cyc);
            end
        end
        prev_stalled = (tx_valid === 1'b1) && !tx_ready && !rst;
        prev_data    = tx_data;
        prev_last    = tx_last;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rx_data.delete();
        rx_last.delete();
        rx_cyc.delete();
        valid_seen = 0;
        first_valid_cyc = -1;
    endtask

    task automatic push_frame(input int n, input int base, output int ccyc);
        for (int i = 0; i < n; i++) begin
            step();
            wr_en = 1'b1;
            wr_data = 8'(base + i);
        end
        step();
        wr_en = 1'b0;
        wr_commit = 1'b1;
        ccyc = cyc;
        step();
        wr_commit = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, input string name);
        int k = 0;
        while (rx_data.size() < n && k < budget) begin
            step();
            k++;
        end
        n_checks++;
        if (rx_data.size() < n) begin
            n_fail++;
            $display("FAIL %s timeout: received %0d bytes, required %0d", name, rx_data.size(), n);
        end
    endtask

    task automatic check_frame(input int n, input int base, input int off, input string name);
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (off + i >= rx_data.size()) begin
                n_fail++;
                $display("FAIL %s byte %0d missing", name, i);
                break;
            end
            if (rx_data[off+i] !== 8'(base + i) || rx_last[off+i] !== (i == n - 1)) begin
                n_fail++;
                $display("FAIL %s byte %0d: data %h last %b, required data %h last %b",
                         name, i, rx_data[off+i], rx_last[off+i], 8'(base + i), (i == n - 1));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk_en = 1'b1;
        n_checks += 6;
        if (tx_valid !== 1'b0)       begin n_fail++; $display("FAIL reset_valid: %b, required 0", tx_valid); end
        if (tx_last !== 1'b0)        begin n_fail++; $display("FAIL reset_last: %b, required 0", tx_last); end
        if (tx_data !== 8'd0)        begin n_fail++; $display("FAIL reset_data: %h, required 00", tx_data); end
        if (free_bytes !== 13'd4096) begin n_fail++; $display("FAIL reset_free: %0d, required 4096", free_bytes); end
        if (frames_pending !== 5'd0) begin n_fail++; $display("FAIL reset_pending: %0d, required 0", frames_pending); end
        if (drop_count !== 16'd0)    begin n_fail++; $display("FAIL reset_drops: %0d, required 0", drop_count); end
    endtask

    task automatic test_basic_frame();
        int c;
        tx_ready = 1'b1;
        clear_rx();
        push_frame(60, 0, c);
        n_checks++;
        if (frames_pending !== 5'd1) begin n_fail++; $display("FAIL basic_pending_up: %0d, required 1", frames_pending); end
        wait_rx(60, 200, "basic_rx");
        n_checks++;
        if (first_valid_cyc != c + 3) begin n_fail++; $display("FAIL basic_latency: first valid cycle %0d, required %0d", first_valid_cyc, c + 3); end
        check_frame(60, 0, 0, "basic_data");
        n_checks += 3;
        if (rx_data.size() != 60)    begin n_fail++; $display("FAIL basic_count: %0d, required 60", rx_data.size()); end
        if (frames_pending !== 5'd0) begin n_fail++; $display("FAIL basic_pending_down: %0d, required 0", frames_pending); end
        if (free_bytes !== 13'd4096) begin n_fail++; $display("FAIL basic_free: %0d, required 4096", free_bytes); end
    endtask

    task automatic test_stall();
        int c, n0, k;
        tx_ready = 1'b1;
        clear_rx();
        push_frame(40, 8'h40, c);
        wait_rx(10, 100, "stall_pre");
        tx_ready = 1'b0;
        n0 = rx_data.size();
        repeat (5) step();
        n_checks++;
        if (rx_data.size() != n0) begin n_fail++; $display("FAIL stall_hold: received %0d, required %0d", rx_data.size(), n0); end
        k = 0;
        while (rx_data.size() < 40 && k < 400) begin
            tx_ready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        tx_ready = 1'b1;
        step();
        check_frame(40, 8'h40, 0, "stall_data");
        n_checks += 2;
        if (rx_data.size() != 40) begin n_fail++; $display("FAIL stall_count: %0d, required 40", rx_data.size()); end
        if (stall_err != 0)       begin n_fail++; $display("FAIL stall_stable: %0d unstable stalled cycles, required 0", stall_err); end
    endtask

    task automatic test_oversize();
        int c;
        tx_ready = 1'b1;
        clear_rx();
        push_frame(2048, 0, c);
        exp_drops++;
        repeat (10) step();
        n_checks += 4;
        if (drop_count !== 16'(exp_drops)) begin n_fail++; $display("FAIL over_drops: %0d, required %0d", drop_count, exp_drops); end
        if (valid_seen != 0)               begin n_fail++; $display("FAIL over_valid: %0d valid cycles, required 0", valid_seen); end
        if (free_bytes !== 13'd4096)       begin n_fail++; $display("FAIL over_free: %0d, required 4096", free_bytes); end
        if (frames_pending !== 5'd0)       begin n_fail++; $display("FAIL over_pending: %0d, required 0", frames_pending); end
        push_frame(10, 8'hA0, c);
        wait_rx(10, 50, "over_next_rx");
        check_frame(10, 8'hA0, 0, "over_next_data");
    endtask

    task automatic test_fill();
        int c;
        tx_ready = 1'b0;
        clear_rx();
        push_frame(2047, 8'h11, c);
        push_frame(2047, 8'h77, c);
        push_frame(10, 8'hC0, c);
        exp_drops++;
        n_checks += 3;
        if (free_bytes !== 13'd2)          begin n_fail++; $display("FAIL fill_free: %0d, required 2", free_bytes); end
        if (drop_count !== 16'(exp_drops)) begin n_fail++; $display("FAIL fill_drops: %0d, required %0d", drop_count, exp_drops); end
        if (frames_pending !== 5'd2)       begin n_fail++; $display("FAIL fill_pending: %0d, required 2", frames_pending); end
        tx_ready = 1'b1;
        wait_rx(4094, 5000, "fill_rx");
        step();
        check_frame(2047, 8'h11, 0, "fill_frame1");
        check_frame(2047, 8'h77, 2047, "fill_frame2");
        n_checks += 3;
        if (rx_cyc.size() >= 2048 && rx_cyc[2047] - rx_cyc[2046] != 3) begin
            n_fail++; $display("FAIL fill_gap: %0d idle cycles, required 2", rx_cyc[2047] - rx_cyc[2046] - 1);
        end
        if (rx_data.size() != 4094)  begin n_fail++; $display("FAIL fill_count: %0d, required 4094", rx_data.size()); end
        if (free_bytes !== 13'd4096) begin n_fail++; $display("FAIL fill_free_end: %0d, required 4096", free_bytes); end
    endtask

    task automatic test_slots();
        tx_ready = 1'b0;
        clear_rx();
        for (int k = 0; k < 17; k++) begin
            step();
            wr_en = 1'b1;
            wr_commit = 1'b1;
            wr_data = 8'(k);
        end
        step();
        wr_en = 1'b0;
        wr_commit = 1'b0;
        exp_drops++;
        n_checks += 2;
        if (frames_pending !== 5'd16)      begin n_fail++; $display("FAIL slots_pending: %0d, required 16", frames_pending); end
        if (drop_count !== 16'(exp_drops)) begin n_fail++; $display("FAIL slots_drops: %0d, required %0d", drop_count, exp_drops); end
        tx_ready = 1'b1;
        wait_rx(16, 200, "slots_rx");
        step();
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (rx_data[k] !== 8'(k) || rx_last[k] !== 1'b1) begin
                n_fail++; $display("FAIL slots_frame %0d: data %h last %b, required data %h last 1", k, rx_data[k], rx_last[k], 8'(k));
            end
        end
        n_checks++;
        if (frames_pending !== 5'd0) begin n_fail++; $display("FAIL slots_drain: %0d, required 0", frames_pending); end
        wr_commit = 1'b1;
        step();
        wr_commit = 1'b0;
        exp_drops++;
        n_checks += 2;
        if (drop_count !== 16'(exp_drops)) begin n_fail++; $display("FAIL empty_commit_drops: %0d, required %0d", drop_count, exp_drops); end
        if (frames_pending !== 5'd0)       begin n_fail++; $display("FAIL empty_commit_pending: %0d, required 0", frames_pending); end
    endtask

    task automatic test_reset_mid_send();
        int c;
        tx_ready = 1'b1;
        clear_rx();
        push_frame(100, 8'h10, c);
        push_frame(20, 8'h90, c);
        wait_rx(30, 100, "rstmid_pre");
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_drops = 0;
        n_checks += 4;
        if (tx_valid !== 1'b0)       begin n_fail++; $display("FAIL rstmid_valid: %b, required 0", tx_valid); end
        if (frames_pending !== 5'd0) begin n_fail++; $display("FAIL rstmid_pending: %0d, required 0", frames_pending); end
        if (free_bytes !== 13'd4096) begin n_fail++; $display("FAIL rstmid_free: %0d, required 4096", free_bytes); end
        if (drop_count !== 16'd0)    begin n_fail++; $display("FAIL rstmid_drops: %0d, required 0", drop_count); end
        clear_rx();
        repeat (30) step();
        n_checks += 2;
        if (valid_seen != 0)      begin n_fail++; $display("FAIL rstmid_quiet_valid: %0d valid cycles, required 0", valid_seen); end
        if (rx_data.size() != 0)  begin n_fail++; $display("FAIL rstmid_quiet_rx: %0d bytes, required 0", rx_data.size()); end
        push_frame(5, 8'h33, c);
        wait_rx(5, 50, "rstmid_after_rx");
        check_frame(5, 8'h33, 0, "rstmid_after_data");
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_stall();
        test_oversize();
        test_fill();
        test_slots();
        test_reset_mid_send();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
